fir_requant_decim: RTL and testbench

Output stage placed directly downstream of `my_fir`. It takes the 32-bit full-precision `filter_out` stream, one sample per clock, and rescales it to 16 bits with round-half-up and saturation. It then decimates the stream by a fixed factor and buffers the kept samples in a small first-word-fall-through FIFO, which presents them to the consumer over a valid/ready handshake. The FIR has no backpressure, so FIFO overflow is flagged rather than stalled.

---
 rtl/fir_requant_decim.sv | 129 ++++++++++++
 tb/tb_fir_requant_decim.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_requant_decim.sv
// Requantizes the 32-bit FIR output stream to 16 bits (round-half-up, saturate),
// decimates it and presents kept samples through a first-word-fall-through FIFO.
module fir_requant_decim #(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   sat_count,
  output logic                          drop
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] RND = EXT_W'(1) << (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] HI  = EXT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [EXT_W-1:0] LO  = ~HI;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;
  logic [OUT_W-1:0]        q;
  logic                    sat;
  logic                    keep;

  logic [PH_W-1:0]  phase;
  logic             s1_valid;
  logic             s1_keep;
  logic             s1_sat;
  logic [OUT_W-1:0] s1_data;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             push;
  logic             kept_s1;

  // Round-half-up and clamp; one extra bit keeps the rounding add from overflowing
  always_comb begin
    ext     = $signed({in_data[IN_W-1], in_data});
    rounded = ext + RND;
    shifted = rounded >>> SHIFT;
    sat     = 1'b0;
    q       = OUT_W'(shifted);
    if (shifted > HI) begin
      q   = OUT_W'(HI);
      sat = 1'b1;
    end else if (shifted < LO) begin
      q   = OUT_W'(LO);
      sat = 1'b1;
    end
  end

  assign keep = (phase == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_keep  <= 1'b0;
      s1_sat   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_keep  <= keep;
      s1_sat   <= in_valid & sat;
      s1_data  <= q;
    end
  end

  // A full FIFO still accepts a write when the head leaves on the same edge
  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign kept_s1   = s1_valid & s1_keep;
  assign push      = kept_s1 & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
      else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
      drop      <= 1'b0;
    end else begin
      if (s1_valid && s1_sat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
      if (kept_s1 && full && !pop) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_requant_decim.sv
// Bench for fir_requant_decim: DECIM=1 and DECIM=4 instances share stimulus and
// are checked each cycle against a queue-based model plus literal expectations.
module tb_fir_requant_decim;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [1:0][15:0]  od;
  logic [1:0]        ov;
  logic [1:0][3:0]   lvl;
  logic [1:0][15:0]  sc;
  logic [1:0]        dr;

  always #5 clk = ~clk;

  fir_requant_decim #(.DECIM(1)) u_d1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .fifo_level(lvl[0]), .sat_count(sc[0]), .drop(dr[0])
  );

  fir_requant_decim #(.DECIM(4)) u_d4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .fifo_level(lvl[1]), .sat_count(sc[1]), .drop(dr[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: 0 -> DECIM=1, 1 -> DECIM=4
  int mq [2][$];
  int got[2][$];
  int phase[2];
  bit pv[2], pk[2], ps[2];
  int pd[2];
  int msat[2];
  bit mdrop[2];
  int e[$];

  function automatic int dec(int m);
    return (m == 0) ? 1 : 4;
  endfunction

  function automatic int requant(input logic [31:0] x, output bit s);
    longint v, r;
    v = longint'($signed(x));
    r = (v + 64'sd16384) >>> 15;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
    return int'(r);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      phase[m] = 0; pv[m] = 0; pk[m] = 0; ps[m] = 0; pd[m] = 0;
      msat[m] = 0; mdrop[m] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_update();
    bit popm, full, s;
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      popm = (mq[m].size() > 0) && out_ready;
      full = (mq[m].size() == 8);
      if (popm) void'(mq[m].pop_front());
      if (pv[m] && pk[m]) begin
        if (!full || popm) mq[m].push_back(pd[m]);
        else mdrop[m] = 1'b1;
      end
      if (pv[m] && ps[m] && msat[m] < 65535) msat[m]++;
      pv[m] = in_valid;
      if (in_valid) begin
        pd[m] = requant(in_data, s);
        ps[m] = s;
        pk[m] = (phase[m] == 0);
        phase[m] = (phase[m] + 1) % dec(m);
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_valid[d%0d]", dec(m)), int'(ov[m]), int'(mq[m].size() > 0));
      chk($sformatf("out_data[d%0d]", dec(m)), int'($signed(od[m])),
          (mq[m].size() > 0) ? mq[m][0] : 0);
      chk($sformatf("fifo_level[d%0d]", dec(m)), int'(lvl[m]), mq[m].size());
      chk($sformatf("drop[d%0d]", dec(m)), int'(dr[m]), int'(mdrop[m]));
      chk($sformatf("sat_count[d%0d]", dec(m)), int'(sc[m]), msat[m]);
    end
  endtask

  task automatic step();
    for (int m = 0; m < 2; m++)
      if (ov[m] && out_ready) got[m].push_back(int'($signed(od[m])));
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic feed(input int x);
    in_valid = 1'b1;
    in_data  = 32'(x);
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    got[0].delete();
    got[1].delete();
  endtask

  task automatic check_log(input int m, input string name, input int exp[$]);
    chk({name, "_count"}, got[m].size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", name, i), (i < got[m].size()) ? got[m][i] : -99999, exp[i]);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_level", int'(lvl[0]), 0);

    // Rounding
    out_ready = 1'b1;
    feed(32768); feed(16384); feed(16383); feed(-16384); feed(-16385); feed(-32768);
    idle(3);
    e = '{1, 1, 0, 0, -1, -1};
    check_log(0, "round", e);

    // Saturation
    do_reset();
    out_ready = 1'b1;
    feed(32'h7FFF_FFFF);
    feed(32'h8000_0000);
    idle(3);
    e = '{32767, -32768};
    check_log(0, "sat", e);
    chk("sat_count_two", int'(sc[0]), 2);
    repeat (10) feed(0);
    idle(3);
    chk("sat_count_hold", int'(sc[0]), 2);

    // Decimation, continuous then gapped
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) feed(k * 32768);
    idle(3);
    e = '{0, 4, 8, 12};
    check_log(1, "decim", e);
    chk("decim_sat_zero", int'(sc[1]), 0);
    do_reset();
    for (int k = 0; k < 16; k++) begin feed(k * 32768); idle(1); end
    idle(3);
    check_log(1, "decim_gap", e);

    // Overflow with consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 40; k++) feed(k * 32768);
    idle(2);
    chk("ovf_level", int'(lvl[1]), 8);
    chk("ovf_drop", int'(dr[1]), 1);
    out_ready = 1'b1;
    idle(10);
    e.delete();
    for (int k = 0; k < 8; k++) e.push_back(4 * k);
    check_log(1, "ovf_drain", e);
    chk("ovf_empty", int'(ov[1]), 0);
    chk("ovf_drop_sticky", int'(dr[1]), 1);

    // Full FIFO with push and pop on the same edge
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) feed((100 + k) * 32768);
    idle(1);
    chk("full_level", int'(lvl[0]), 8);
    feed(108 * 32768);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("pushpop_level", int'(lvl[0]), 8);
    chk("pushpop_drop", int'(dr[0]), 0);
    out_ready = 1'b1;
    idle(10);
    e.delete();
    for (int k = 0; k < 9; k++) e.push_back(100 + k);
    check_log(0, "pushpop_order", e);

    // Asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b0;
    feed(32'h7FFF_FFFF); feed(32'h7FFF_FFFF); feed(32'h7FFF_FFFF);
    feed(0); feed(0);
    idle(2);
    chk("pre_rst_level", int'(lvl[0]), 5);
    chk("pre_rst_sat", int'(sc[0]), 3);
    #2;
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("async_rst_valid[d%0d]", dec(m)), int'(ov[m]), 0);
      chk($sformatf("async_rst_data[d%0d]", dec(m)), int'(od[m]), 0);
      chk($sformatf("async_rst_level[d%0d]", dec(m)), int'(lvl[m]), 0);
      chk($sformatf("async_rst_sat[d%0d]", dec(m)), int'(sc[m]), 0);
      chk($sformatf("async_rst_drop[d%0d]", dec(m)), int'(dr[m]), 0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    got[0].delete();
    got[1].delete();
    feed(7 * 32768);
    idle(1);
    chk("post_rst_valid_d1", int'(ov[0]), 1);
    chk("post_rst_data_d1", int'($signed(od[0])), 7);
    chk("post_rst_valid_d4", int'(ov[1]), 1);
    chk("post_rst_data_d4", int'($signed(od[1])), 7);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
